// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: opcodes, states,
// ALU-control ops and datapath mux selects.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EXEC_R    = 4'd3,
        S_R_WB      = 4'd4,
        S_MEM_ADDR  = 4'd5,
        S_MEM_RD    = 4'd6,
        S_LW_WB     = 4'd7,
        S_MEM_WR    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_BRANCH_NE = 4'd12,
        S_TRAP      = 4'd15
    } mc_state_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b11;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that wait on the memory ready handshake.
    function automatic logic is_mem_state(input mc_state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait-cycle counter; expired_o flags the wait cycle that reaches
// TIMEOUT_CYC with ready still low. TIMEOUT_CYC = 0 never expires.
module mc_wait_timer #(
    parameter int TMR_W       = 4,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [TMR_W-1:0] LAST_CNT =
        (TIMEOUT_CYC > 0) ? TMR_W'(TIMEOUT_CYC - 1) : '0;

    logic [TMR_W-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
        end else if (clear_i) begin
            r_cnt <= '0;
        end else if (enable_i && (r_cnt != LAST_CNT)) begin
            r_cnt <= r_cnt + TMR_W'(1);
        end
    end

    // Ready in the same cycle as the final count wins, so expiry is gated by enable.
    assign expired_o = (TIMEOUT_CYC != 0) && enable_i && (r_cnt == LAST_CNT);

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath with memory-wait timeout trap.
// Optional bne support is built when MC_CTRL_BNE_EN is defined.
//
// state     | meaning
// IDLE      | after reset, all strobes low
// FETCH     | read instruction; IR/PC load on ready
// DECODE    | branch target compute, opcode dispatch
// EXEC_R    | R-type ALU op
// R_WB      | write rd
// MEM_ADDR  | base + imm for lw/sw/addi
// MEM_RD    | data read, waits on ready
// LW_WB     | write MDR to rt
// MEM_WR    | data write, waits on ready
// I_WB      | write ALUOut to rt
// BRANCH    | beq compare and conditional PC load
// BRANCH_NE | bne compare, zero inverted by datapath
// JUMP      | PC <- jump target
// TRAP      | halted until reset
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W        = 6,
    parameter int ALUOP_W     = 2,
    parameter int TIMEOUT_CYC = 15,
    parameter int TMR_W       = 4
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [OP_W-1:0]    Op_i,
    input  logic               mem_ready_i,
    output logic               PCWrite_o,
    output logic               PCWriteCond_o,
    output logic               IorD_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               IRWrite_o,
    output logic               MemToReg_o,
    output logic               RegDst_o,
    output logic               RegWrite_o,
    output logic               ALUSrcA_o,
    output logic [1:0]         ALUSrcB_o,
    output logic [1:0]         PCSource_o,
    output logic [ALUOP_W-1:0] ALUOp_o,
    output logic               illegal_o,
    output logic               timeout_o,
`ifdef MC_CTRL_BNE_EN
    output logic               bne_o,
`endif
    output logic [3:0]         state_o
);

    mc_state_e       r_state;
    mc_state_e       w_next;
    logic [OP_W-1:0] r_op;
    logic            r_illegal;
    logic            r_timeout;
    logic            w_in_mem;
    logic            w_expired;
    logic            w_bad_op;

    assign w_in_mem = is_mem_state(r_state);

    mc_wait_timer #(
        .TMR_W       (TMR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait_timer (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .clear_i   (!w_in_mem || mem_ready_i),
        .enable_i  (w_in_mem && !mem_ready_i),
        .expired_o (w_expired)
    );

    always_comb begin
        w_next   = r_state;
        w_bad_op = 1'b0;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH:  if (mem_ready_i) w_next = S_DECODE;
                      else if (w_expired) w_next = S_TRAP;
            S_DECODE: begin
                case (Op_i)
                    OP_W'(OP_RTYPE): w_next = S_EXEC_R;
                    OP_W'(OP_LW),
                    OP_W'(OP_SW),
                    OP_W'(OP_ADDI):  w_next = S_MEM_ADDR;
                    OP_W'(OP_BEQ):   w_next = S_BRANCH;
                    OP_W'(OP_J):     w_next = S_JUMP;
`ifdef MC_CTRL_BNE_EN
                    OP_W'(OP_BNE):   w_next = S_BRANCH_NE;
`endif
                    default: begin
                        w_next   = S_TRAP;
                        w_bad_op = 1'b1;
                    end
                endcase
            end
            S_EXEC_R:   w_next = S_R_WB;
            S_MEM_ADDR: begin
                if (r_op == OP_W'(OP_LW))      w_next = S_MEM_RD;
                else if (r_op == OP_W'(OP_SW)) w_next = S_MEM_WR;
                else                           w_next = S_I_WB;
            end
            S_MEM_RD: if (mem_ready_i) w_next = S_LW_WB;
                      else if (w_expired) w_next = S_TRAP;
            S_MEM_WR: if (mem_ready_i) w_next = S_FETCH;
                      else if (w_expired) w_next = S_TRAP;
            S_R_WB, S_LW_WB, S_I_WB,
            S_BRANCH, S_BRANCH_NE, S_JUMP: w_next = S_FETCH;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) r_op <= Op_i;
            if (w_bad_op)  r_illegal <= 1'b1;
            if (w_expired) r_timeout <= 1'b1;
        end
    end

    // Moore decode; only the fetch-side IR/PC loads look at mem_ready_i.
    always_comb begin
        PCWrite_o     = 1'b0;
        PCWriteCond_o = 1'b0;
        IorD_o        = 1'b0;
        MemRead_o     = 1'b0;
        MemWrite_o    = 1'b0;
        IRWrite_o     = 1'b0;
        MemToReg_o    = 1'b0;
        RegDst_o      = 1'b0;
        RegWrite_o    = 1'b0;
        ALUSrcA_o     = 1'b0;
        ALUSrcB_o     = SRCB_RT;
        PCSource_o    = PCSRC_ALU;
        ALUOp_o       = ALUOP_W'(ALUOP_ADD);
        case (r_state)
            S_FETCH: begin
                MemRead_o = 1'b1;
                ALUSrcB_o = SRCB_FOUR;
                IRWrite_o = mem_ready_i;
                PCWrite_o = mem_ready_i;
            end
            S_DECODE: ALUSrcB_o = SRCB_IMM_SH;
            S_EXEC_R: begin
                ALUSrcA_o = 1'b1;
                ALUOp_o   = ALUOP_W'(ALUOP_FUNCT);
            end
            S_R_WB: begin
                RegDst_o   = 1'b1;
                RegWrite_o = 1'b1;
            end
            S_MEM_ADDR: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = SRCB_IMM;
            end
            S_MEM_RD: begin
                MemRead_o = 1'b1;
                IorD_o    = 1'b1;
            end
            S_LW_WB: begin
                MemToReg_o = 1'b1;
                RegWrite_o = 1'b1;
            end
            S_MEM_WR: begin
                MemWrite_o = 1'b1;
                IorD_o     = 1'b1;
            end
            S_I_WB: RegWrite_o = 1'b1;
            S_BRANCH, S_BRANCH_NE: begin
                ALUSrcA_o     = 1'b1;
                ALUOp_o       = ALUOP_W'(ALUOP_SUB);
                PCWriteCond_o = 1'b1;
                PCSource_o    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                PCWrite_o  = 1'b1;
                PCSource_o = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    assign illegal_o = r_illegal;
    assign timeout_o = r_timeout;
    assign state_o   = r_state;
`ifdef MC_CTRL_BNE_EN
    assign bne_o     = (r_state == S_BRANCH_NE);
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control; strobe vectors are hand-computed.
module tb_multicycle_control;
    import mc_ctrl_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic [5:0] Op_i;
    logic       mem_ready_i;
    logic       PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o;
    logic       MemToReg_o, RegDst_o, RegWrite_o, ALUSrcA_o;
    logic [1:0] ALUSrcB_o, PCSource_o, ALUOp_o;
    logic       illegal_o, timeout_o;
    logic [3:0] state_o;
`ifdef MC_CTRL_BNE_EN
    logic       bne_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemToReg,RegDst,
    //  RegWrite,ALUSrcA,ALUSrcB[1:0],PCSource[1:0],ALUOp[1:0]}
    logic [15:0] ctl;
    assign ctl = {PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
                  MemToReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, PCSource_o, ALUOp_o};

    localparam logic [15:0] C_NONE     = 16'h0000;
    localparam logic [15:0] C_FETCH    = 16'h9410;
    localparam logic [15:0] C_FETCH_WT = 16'h1010;
    localparam logic [15:0] C_DECODE   = 16'h0030;
    localparam logic [15:0] C_EXEC_R   = 16'h0043;
    localparam logic [15:0] C_R_WB     = 16'h0180;
    localparam logic [15:0] C_MEM_ADDR = 16'h0060;
    localparam logic [15:0] C_MEM_RD   = 16'h3000;
    localparam logic [15:0] C_LW_WB    = 16'h0280;
    localparam logic [15:0] C_MEM_WR   = 16'h2800;
    localparam logic [15:0] C_I_WB     = 16'h0080;
    localparam logic [15:0] C_BRANCH   = 16'h4045;
    localparam logic [15:0] C_JUMP     = 16'h8008;

    multicycle_control #(
        .OP_W(6), .ALUOP_W(2), .TIMEOUT_CYC(15), .TMR_W(4)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .Op_i(Op_i), .mem_ready_i(mem_ready_i),
        .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o), .IorD_o(IorD_o),
        .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .IRWrite_o(IRWrite_o),
        .MemToReg_o(MemToReg_o), .RegDst_o(RegDst_o), .RegWrite_o(RegWrite_o),
        .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .PCSource_o(PCSource_o),
        .ALUOp_o(ALUOp_o), .illegal_o(illegal_o), .timeout_o(timeout_o),
`ifdef MC_CTRL_BNE_EN
        .bne_o(bne_o),
`endif
        .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_sc(input string tag, input mc_state_e st, input logic [15:0] c);
        chk({tag, ".state"}, 32'(state_o), 32'(st));
        chk({tag, ".ctl"}, 32'(ctl), 32'(c));
    endtask

    // Advance to the next cycle and drive that cycle's inputs.
    task automatic cyc(input logic rdy, input logic [5:0] op);
        @(negedge clk_i);
        mem_ready_i = rdy;
        Op_i        = op;
        #1;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk_i);
        rst_n_i = 1'b0;
        #1;
        chk_sc({tag, ".rst"}, S_IDLE, C_NONE);
        chk({tag, ".rst_ill"}, 32'(illegal_o), 32'h0);
        chk({tag, ".rst_to"}, 32'(timeout_o), 32'h0);
        @(negedge clk_i);
        rst_n_i     = 1'b1;
        mem_ready_i = 1'b1;
        #1;
        chk_sc({tag, ".idle"}, S_IDLE, C_NONE);
    endtask

    initial begin
        rst_n_i     = 1'b0;
        mem_ready_i = 1'b1;
        Op_i        = 6'd0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        #1;
        chk_sc("reset", S_IDLE, C_NONE);
        chk("reset.ill", 32'(illegal_o), 32'h0);
        chk("reset.to", 32'(timeout_o), 32'h0);
        rst_n_i = 1'b1;
        #1;
        chk_sc("idle", S_IDLE, C_NONE);

        // R-type
        cyc(1'b1, 6'd0);     chk_sc("r.fetch", S_FETCH, C_FETCH);
        cyc(1'b1, OP_RTYPE); chk_sc("r.decode", S_DECODE, C_DECODE);
        cyc(1'b1, 6'd0);     chk_sc("r.exec", S_EXEC_R, C_EXEC_R);
        cyc(1'b1, 6'd0);     chk_sc("r.wb", S_R_WB, C_R_WB);

        // lw with two wait cycles in MEM_RD: 7 cycles
        cyc(1'b1, 6'd0);  chk_sc("lw.fetch", S_FETCH, C_FETCH);
        cyc(1'b1, OP_LW); chk_sc("lw.decode", S_DECODE, C_DECODE);
        cyc(1'b1, 6'd0);  chk_sc("lw.addr", S_MEM_ADDR, C_MEM_ADDR);
        cyc(1'b0, 6'd0);  chk_sc("lw.rd1", S_MEM_RD, C_MEM_RD);
        cyc(1'b0, 6'd0);  chk_sc("lw.rd2", S_MEM_RD, C_MEM_RD);
        cyc(1'b1, 6'd0);  chk_sc("lw.rd3", S_MEM_RD, C_MEM_RD);
        cyc(1'b1, 6'd0);  chk_sc("lw.wb", S_LW_WB, C_LW_WB);

        // addi with one fetch wait cycle
        cyc(1'b0, 6'd0);    chk_sc("addi.fwait", S_FETCH, C_FETCH_WT);
        cyc(1'b1, 6'd0);    chk_sc("addi.fetch", S_FETCH, C_FETCH);
        cyc(1'b1, OP_ADDI); chk_sc("addi.decode", S_DECODE, C_DECODE);
        cyc(1'b1, 6'd0);    chk_sc("addi.addr", S_MEM_ADDR, C_MEM_ADDR);
        cyc(1'b1, 6'd0);    chk_sc("addi.wb", S_I_WB, C_I_WB);

        // sw, zero wait
        cyc(1'b1, 6'd0);  chk_sc("sw0.fetch", S_FETCH, C_FETCH);
        cyc(1'b1, OP_SW); chk_sc("sw0.decode", S_DECODE, C_DECODE);
        cyc(1'b1, 6'd0);  chk_sc("sw0.addr", S_MEM_ADDR, C_MEM_ADDR);
        cyc(1'b1, 6'd0);  chk_sc("sw0.wr", S_MEM_WR, C_MEM_WR);

        // sw, ready arrives in the 15th write cycle: completes normally
        cyc(1'b1, 6'd0);  chk_sc("swb.fetch", S_FETCH, C_FETCH);
        cyc(1'b1, OP_SW); chk_sc("swb.decode", S_DECODE, C_DECODE);
        cyc(1'b1, 6'd0);  chk_sc("swb.addr", S_MEM_ADDR, C_MEM_ADDR);
        for (int i = 0; i < 14; i++) begin
            cyc(1'b0, 6'd0); chk_sc("swb.wait", S_MEM_WR, C_MEM_WR);
        end
        cyc(1'b1, 6'd0);  chk_sc("swb.last", S_MEM_WR, C_MEM_WR);
        cyc(1'b1, 6'd0);  chk_sc("swb.done", S_FETCH, C_FETCH);
        chk("swb.to", 32'(timeout_o), 32'h0);

        // beq then j
        cyc(1'b1, OP_BEQ); chk_sc("beq.decode", S_DECODE, C_DECODE);
        cyc(1'b1, 6'd0);   chk_sc("beq.branch", S_BRANCH, C_BRANCH);
        cyc(1'b1, 6'd0);   chk_sc("j.fetch", S_FETCH, C_FETCH);
        cyc(1'b1, OP_J);   chk_sc("j.decode", S_DECODE, C_DECODE);
        cyc(1'b1, 6'd0);   chk_sc("j.jump", S_JUMP, C_JUMP);

        // bne
        cyc(1'b1, 6'd0);   chk_sc("bne.fetch", S_FETCH, C_FETCH);
        cyc(1'b1, OP_BNE); chk_sc("bne.decode", S_DECODE, C_DECODE);
        cyc(1'b1, 6'd0);
`ifdef MC_CTRL_BNE_EN
        chk_sc("bne.branch", S_BRANCH_NE, C_BRANCH);
        chk("bne.flag", 32'(bne_o), 32'h1);
        chk("bne.ill", 32'(illegal_o), 32'h0);
`else
        chk_sc("bne.trap", S_TRAP, C_NONE);
        chk("bne.ill", 32'(illegal_o), 32'h1);
        do_reset("bne");
`endif

        // illegal opcode traps; reset clears and refetches
        cyc(1'b1, 6'd0);         chk_sc("ill.fetch", S_FETCH, C_FETCH);
        cyc(1'b1, 6'b111111);    chk_sc("ill.decode", S_DECODE, C_DECODE);
        cyc(1'b1, 6'd0);         chk_sc("ill.trap", S_TRAP, C_NONE);
        chk("ill.flag", 32'(illegal_o), 32'h1);
        chk("ill.to", 32'(timeout_o), 32'h0);
        cyc(1'b1, 6'd0);         chk_sc("ill.hold", S_TRAP, C_NONE);
        do_reset("ill");

        // sw timeout: 15 write cycles, then TRAP
        cyc(1'b1, 6'd0);  chk_sc("swt.fetch", S_FETCH, C_FETCH);
        cyc(1'b1, OP_SW); chk_sc("swt.decode", S_DECODE, C_DECODE);
        cyc(1'b1, 6'd0);  chk_sc("swt.addr", S_MEM_ADDR, C_MEM_ADDR);
        for (int i = 0; i < 15; i++) begin
            cyc(1'b0, 6'd0); chk_sc("swt.wait", S_MEM_WR, C_MEM_WR);
            chk("swt.to_lo", 32'(timeout_o), 32'h0);
        end
        cyc(1'b0, 6'd0);  chk_sc("swt.trap", S_TRAP, C_NONE);
        chk("swt.to", 32'(timeout_o), 32'h1);
        chk("swt.ill", 32'(illegal_o), 32'h0);
        cyc(1'b1, 6'd0);  chk_sc("swt.rdy", S_TRAP, C_NONE);
        chk("swt.to_hold", 32'(timeout_o), 32'h1);
        do_reset("swt");
        cyc(1'b1, 6'd0);  chk_sc("post.fetch", S_FETCH, C_FETCH);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
